// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl
// Captures requests into a pending register, masks them and grants the
// highest-indexed eligible line. A grant is held stable until the consumer
// acknowledges it. Dropping enable withdraws the grant without consuming it.
module priority_irq_ctrl #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int EDGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] op,
  output logic [N-1:0] pending
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_req_d;
  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_op;

  state_t       w_state_nxt;
  logic         w_valid_nxt;
  logic [W-1:0] w_op_nxt;
  logic [N-1:0] w_capture;
  logic [N-1:0] w_clear;
  logic [N-1:0] w_eligible;
  logic [N-1:0] w_pending_nxt;
  logic [W-1:0] w_winner;
  logic         w_any;

  // Request capture: rising edges against the delayed copy, or raw level.
  always_comb begin
    w_capture = '0;
    if (EDGE != 0) begin
      w_capture = req & ~r_req_d;
    end else begin
      w_capture = req;
    end
  end

  // Eligible lines and the highest-indexed winner among them.
  always_comb begin
    w_eligible = r_pending & ~mask;
    w_any      = |w_eligible;
    w_winner   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_eligible[i]) begin
        w_winner = W'(i);
      end
    end
  end

  // Next state, grant outputs and the pending-bit clear on acknowledge.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_op_nxt    = r_op;
    w_clear     = '0;
    unique case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (en && w_any) begin
          w_state_nxt = GRANT;
          w_valid_nxt = 1'b1;
          w_op_nxt    = w_winner;
        end
      end
      GRANT: begin
        // Acknowledge consumes the grant even if enable drops the same cycle.
        if (ack) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          for (int unsigned i = 0; i < N; i++) begin
            if (r_op == W'(i)) begin
              w_clear[i] = 1'b1;
            end
          end
        end else if (!en) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // A capture on the same edge as a clear wins, so the line stays pending.
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clear) | w_capture;
  end

  // State, grant and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_pending <= '0;
      r_req_d   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_op      <= w_op_nxt;
      r_pending <= w_pending_nxt;
      r_req_d   <= req;
    end
  end

  assign valid   = r_valid;
  assign op      = r_op;
  assign pending = r_pending;

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Directed bench for priority_irq_ctrl: an N=8 edge-capture instance and an
// N=16 level-capture instance sharing clock and reset.
module tb_priority_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_en, a_ack, a_valid;
  logic [7:0]  a_req, a_mask, a_pending;
  logic [2:0]  a_op;

  logic        b_en, b_ack, b_valid;
  logic [15:0] b_req, b_mask, b_pending;
  logic [3:0]  b_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_irq_ctrl #(.N(8), .W(3), .EDGE(1)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .req(a_req), .mask(a_mask), .ack(a_ack),
    .valid(a_valid), .op(a_op), .pending(a_pending)
  );

  priority_irq_ctrl #(.N(16), .W(4), .EDGE(0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .req(b_req), .mask(b_mask), .ack(b_ack),
    .valid(b_valid), .op(b_op), .pending(b_pending)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_en = 1'b0; a_ack = 1'b0; a_req = '0; a_mask = '0;
    b_en = 1'b0; b_ack = 1'b0; b_req = '0; b_mask = '0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
    n_checks++; if (a_op !== 3'd0) begin n_fail++; $display("FAIL reset_a_op got=%0d exp=0", a_op); end
    n_checks++; if (a_pending !== 8'h00) begin n_fail++; $display("FAIL reset_a_pending got=%h exp=00", a_pending); end
    n_checks++; if (b_valid !== 1'b0 || b_pending !== 16'h0000) begin n_fail++; $display("FAIL reset_b got valid=%b pending=%h exp 0/0000", b_valid, b_pending); end
  endtask

  task automatic test_basic();
    a_en = 1'b1; a_mask = '0;
    a_req = 8'b0010_0100;
    step();
    a_req = '0;
    n_checks++; if (a_pending !== 8'h24) begin n_fail++; $display("FAIL basic_capture got=%h exp=24", a_pending); end
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 got=%b exp=0", a_valid); end
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd5) begin n_fail++; $display("FAIL basic_grant5 got valid=%b op=%0d exp 1/5", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    n_checks++; if (a_valid !== 1'b0 || a_pending !== 8'h04) begin n_fail++; $display("FAIL basic_ack got valid=%b pending=%h exp 0/04", a_valid, a_pending); end
    n_checks++; if (a_op !== 3'd5) begin n_fail++; $display("FAIL basic_op_retain got=%0d exp=5", a_op); end
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd2) begin n_fail++; $display("FAIL basic_grant2 got valid=%b op=%0d exp 1/2", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    n_checks++; if (a_pending !== 8'h00) begin n_fail++; $display("FAIL basic_drain got=%h exp=00", a_pending); end
    step();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_idle got=%b exp=0", a_valid); end
  endtask

  task automatic test_mask();
    a_mask = 8'h80;
    a_req  = 8'h82;
    step();
    a_req = '0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd1) begin n_fail++; $display("FAIL mask_grant1 got valid=%b op=%0d exp 1/1", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    n_checks++; if (a_pending !== 8'h80) begin n_fail++; $display("FAIL mask_pending7 got=%h exp=80", a_pending); end
    step();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL mask_no_grant got=%b exp=0", a_valid); end
    a_mask = '0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd7) begin n_fail++; $display("FAIL mask_unmask_grant7 got valid=%b op=%0d exp 1/7", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    step();
  endtask

  task automatic test_hold();
    a_req = 8'h01;
    step();
    a_req = '0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd0) begin n_fail++; $display("FAIL hold_grant0 got valid=%b op=%0d exp 1/0", a_valid, a_op); end
    a_req = 8'h80;
    for (int i = 0; i < 10; i++) begin
      step();
      a_req = '0;
      n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd0) begin n_fail++; $display("FAIL hold_stable cycle=%0d got valid=%b op=%0d exp 1/0", i, a_valid, a_op); end
    end
    n_checks++; if (a_pending !== 8'h81) begin n_fail++; $display("FAIL hold_pending got=%h exp=81", a_pending); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd7) begin n_fail++; $display("FAIL hold_next7 got valid=%b op=%0d exp 1/7", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    a_req = 8'h08;
    step();
    a_req = '0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd3) begin n_fail++; $display("FAIL b2b_grant3 got valid=%b op=%0d exp 1/3", a_valid, a_op); end
    a_ack = 1'b1;
    a_req = 8'h08;
    step();
    a_ack = 1'b0;
    a_req = '0;
    n_checks++; if (a_pending !== 8'h08 || a_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_set_wins got pending=%h valid=%b exp 08/0", a_pending, a_valid); end
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd3) begin n_fail++; $display("FAIL b2b_regrant3 got valid=%b op=%0d exp 1/3", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    n_checks++; if (a_pending !== 8'h00) begin n_fail++; $display("FAIL b2b_drain got=%h exp=00", a_pending); end
  endtask

  task automatic test_enable();
    a_req = 8'h10;
    step();
    a_req = '0;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd4) begin n_fail++; $display("FAIL en_grant4 got valid=%b op=%0d exp 1/4", a_valid, a_op); end
    a_en = 1'b0;
    step();
    n_checks++; if (a_valid !== 1'b0 || a_pending !== 8'h10) begin n_fail++; $display("FAIL en_drop got valid=%b pending=%h exp 0/10", a_valid, a_pending); end
    step();
    n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL en_stay_idle got=%b exp=0", a_valid); end
    a_en = 1'b1;
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd4) begin n_fail++; $display("FAIL en_regrant4 got valid=%b op=%0d exp 1/4", a_valid, a_op); end
    a_ack = 1'b1;
    step();
    step();
    a_ack = 1'b0;
    n_checks++; if (a_valid !== 1'b0 || a_pending !== 8'h00) begin n_fail++; $display("FAIL en_ack_idle got valid=%b pending=%h exp 0/00", a_valid, a_pending); end
  endtask

  task automatic test_reset_mid();
    a_req = 8'hFF;
    step();
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd7 || a_pending !== 8'hFF) begin n_fail++; $display("FAIL rstmid_pre got valid=%b op=%0d pending=%h exp 1/7/FF", a_valid, a_op, a_pending); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (a_valid !== 1'b0 || a_op !== 3'd0 || a_pending !== 8'h00) begin n_fail++; $display("FAIL rstmid_clear got valid=%b op=%0d pending=%h exp 0/0/00", a_valid, a_op, a_pending); end
    step();
    a_req = '0;
    n_checks++; if (a_pending !== 8'hFF || a_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_first_capture got pending=%h valid=%b exp FF/0", a_pending, a_valid); end
    step();
    n_checks++; if (a_valid !== 1'b1 || a_op !== 3'd7) begin n_fail++; $display("FAIL rstmid_regrant got valid=%b op=%0d exp 1/7", a_valid, a_op); end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_level();
    b_en  = 1'b1;
    b_req = 16'h1000;
    step();
    n_checks++; if (b_pending !== 16'h1000 || b_valid !== 1'b0) begin n_fail++; $display("FAIL level_capture got pending=%h valid=%b exp 1000/0", b_pending, b_valid); end
    step();
    n_checks++; if (b_valid !== 1'b1 || b_op !== 4'd12) begin n_fail++; $display("FAIL level_grant12 got valid=%b op=%0d exp 1/12", b_valid, b_op); end
    b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    n_checks++; if (b_pending !== 16'h1000 || b_valid !== 1'b0) begin n_fail++; $display("FAIL level_repend got pending=%h valid=%b exp 1000/0", b_pending, b_valid); end
    step();
    n_checks++; if (b_valid !== 1'b1 || b_op !== 4'd12) begin n_fail++; $display("FAIL level_regrant12 got valid=%b op=%0d exp 1/12", b_valid, b_op); end
    b_req = '0;
    b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    n_checks++; if (b_pending !== 16'h0000 || b_valid !== 1'b0) begin n_fail++; $display("FAIL level_release got pending=%h valid=%b exp 0000/0", b_pending, b_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_hold();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_level();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
